// File: rtl/rvh_l1d_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rvh_l1d_pkg
//  Brief    : Shared types and default sizes for the L1D MSHR table.
//  Revision : 1.0  initial release
// ============================================================================
package rvh_l1d_pkg;

    localparam int c_mshr_num    = 4;
    localparam int c_mshr_id_w   = 2;
    localparam int c_line_addr_w = 34;

    // Lifecycle of one miss-status holding register
    typedef enum logic [1:0] {
        MSHR_IDLE      = 2'd0,
        MSHR_REQ       = 2'd1,
        MSHR_WAIT_RESP = 2'd2,
        MSHR_REFILL    = 2'd3
    } mshr_state_e;

endpackage
`default_nettype wire

// File: rtl/rvh_l1d_mshr_entry.sv
`default_nettype none
// ============================================================================
//  Module   : rvh_l1d_mshr_entry
//  Brief    : One MSHR entry: lifecycle FSM, line address register and the
//             lookup comparators used for merge / stall decisions.
//  Revision : 1.0  initial release
// ============================================================================
module rvh_l1d_mshr_entry
    import rvh_l1d_pkg::*;
#(
    parameter int LINE_ADDR_W = c_line_addr_w
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc,
    input  logic [LINE_ADDR_W-1:0] alloc_line_addr,
    input  logic                   l2_grant,
    input  logic                   resp_hit,
    input  logic                   refill_grant,
    input  logic [LINE_ADDR_W-1:0] lookup_line_addr,
    output mshr_state_e            state,
    output logic                   valid,
    output logic                   match,
    output logic                   blocking_match,
    output logic [LINE_ADDR_W-1:0] line_addr
);

    mshr_state_e            r_state;
    mshr_state_e            w_state_nxt;
    logic [LINE_ADDR_W-1:0] r_line_addr;
    logic                   w_addr_eq;

    // Next-state: each transition fires only on its own event in its own state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MSHR_IDLE:      if (alloc)        w_state_nxt = MSHR_REQ;
            MSHR_REQ:       if (l2_grant)     w_state_nxt = MSHR_WAIT_RESP;
            MSHR_WAIT_RESP: if (resp_hit)     w_state_nxt = MSHR_REFILL;
            MSHR_REFILL:    if (refill_grant) w_state_nxt = MSHR_IDLE;
            default:                          w_state_nxt = MSHR_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MSHR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Line address captured when the entry is opened
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_addr <= '0;
        end else if (alloc && (r_state == MSHR_IDLE)) begin
            r_line_addr <= alloc_line_addr;
        end
    end

    assign w_addr_eq      = (r_line_addr == lookup_line_addr);
    assign match          = w_addr_eq & ((r_state == MSHR_REQ) | (r_state == MSHR_WAIT_RESP));
    assign blocking_match = w_addr_eq & (r_state == MSHR_REFILL);
    assign valid          = (r_state != MSHR_IDLE);
    assign state          = r_state;
    assign line_addr      = r_line_addr;

endmodule
`default_nettype wire

// File: rtl/rvh_l1d_mshr_table.sv
`default_nettype none
// ============================================================================
//  Module   : rvh_l1d_mshr_table
//  Brief    : MSHR state table for the L1D miss path. Opens entries on new
//             misses, merges secondary misses, arbitrates L2 refill requests
//             and hands completed refills to the data-array write stage.
//  Revision : 1.0  initial release
// ============================================================================
module rvh_l1d_mshr_table
    import rvh_l1d_pkg::*;
#(
    parameter int MSHR_NUM    = c_mshr_num,
    parameter int MSHR_ID_W   = c_mshr_id_w,
    parameter int LINE_ADDR_W = c_line_addr_w
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_vld_i,
    input  logic [LINE_ADDR_W-1:0] miss_line_addr_i,
    output logic                   miss_rdy_o,
    output logic [MSHR_ID_W-1:0]   miss_mshr_id_o,
    output logic                   miss_merged_o,
    input  logic                   alloc_has_free_i,
    input  logic [MSHR_ID_W-1:0]   alloc_id_i,
    output logic [MSHR_NUM-1:0]    mshr_bank_valid_o,
    output logic                   l2_req_vld_o,
    input  logic                   l2_req_rdy_i,
    output logic [LINE_ADDR_W-1:0] l2_req_line_addr_o,
    output logic [MSHR_ID_W-1:0]   l2_req_mshr_id_o,
    input  logic                   l2_resp_vld_i,
    input  logic [MSHR_ID_W-1:0]   l2_resp_mshr_id_i,
    output logic                   refill_vld_o,
    input  logic                   refill_rdy_i,
    output logic [MSHR_ID_W-1:0]   refill_mshr_id_o,
    output logic [LINE_ADDR_W-1:0] refill_line_addr_o
);

    mshr_state_e            w_state     [MSHR_NUM];
    logic [LINE_ADDR_W-1:0] w_line_addr [MSHR_NUM];
    logic [MSHR_NUM-1:0]    w_valid;
    logic [MSHR_NUM-1:0]    w_match;
    logic [MSHR_NUM-1:0]    w_block;
    logic [MSHR_NUM-1:0]    w_is_req;
    logic [MSHR_NUM-1:0]    w_is_wait;
    logic [MSHR_NUM-1:0]    w_is_refill;
    logic [MSHR_NUM-1:0]    w_alloc;
    logic [MSHR_NUM-1:0]    w_l2_grant;
    logic [MSHR_NUM-1:0]    w_resp_hit;
    logic [MSHR_NUM-1:0]    w_refill_grant;

    logic                   w_match_any;
    logic                   w_block_any;
    logic [MSHR_ID_W-1:0]   w_match_id;
    logic                   w_req_any;
    logic [MSHR_ID_W-1:0]   w_req_low;
    logic                   w_rf_any;
    logic [MSHR_ID_W-1:0]   w_rf_low;
    logic [MSHR_ID_W-1:0]   w_l2_sel;
    logic [MSHR_ID_W-1:0]   w_rf_sel;

    logic                   r_l2_hold;
    logic [MSHR_ID_W-1:0]   r_l2_hold_id;
    logic                   r_rf_hold;
    logic [MSHR_ID_W-1:0]   r_rf_hold_id;

    generate
        for (genvar i = 0; i < MSHR_NUM; i++) begin : g_entry
            assign w_alloc[i]        = miss_rdy_o & ~w_match_any & (alloc_id_i == MSHR_ID_W'(i));
            assign w_l2_grant[i]     = l2_req_vld_o & l2_req_rdy_i & (w_l2_sel == MSHR_ID_W'(i));
            assign w_resp_hit[i]     = l2_resp_vld_i & (l2_resp_mshr_id_i == MSHR_ID_W'(i));
            assign w_refill_grant[i] = refill_vld_o & refill_rdy_i & (w_rf_sel == MSHR_ID_W'(i));
            assign w_is_req[i]       = (w_state[i] == MSHR_REQ);
            assign w_is_wait[i]      = (w_state[i] == MSHR_WAIT_RESP);
            assign w_is_refill[i]    = (w_state[i] == MSHR_REFILL);

            rvh_l1d_mshr_entry #(
                .LINE_ADDR_W (LINE_ADDR_W)
            ) u_entry (
                .clk              (clk),
                .rst              (rst),
                .alloc            (w_alloc[i]),
                .alloc_line_addr  (miss_line_addr_i),
                .l2_grant         (w_l2_grant[i]),
                .resp_hit         (w_resp_hit[i]),
                .refill_grant     (w_refill_grant[i]),
                .lookup_line_addr (miss_line_addr_i),
                .state            (w_state[i]),
                .valid            (w_valid[i]),
                .match            (w_match[i]),
                .blocking_match   (w_block[i]),
                .line_addr        (w_line_addr[i])
            );
        end
    endgenerate

    // Merge target: at most one entry can match, so a priority scan suffices
    always_comb begin
        w_match_id = '0;
        for (int i = MSHR_NUM - 1; i >= 0; i--) begin
            if (w_match[i]) w_match_id = MSHR_ID_W'(i);
        end
    end

    // Lowest-index entry waiting to issue, and lowest-index entry ready to retire
    always_comb begin
        w_req_any = 1'b0;
        w_req_low = '0;
        w_rf_any  = 1'b0;
        w_rf_low  = '0;
        for (int i = MSHR_NUM - 1; i >= 0; i--) begin
            if (w_is_req[i]) begin
                w_req_any = 1'b1;
                w_req_low = MSHR_ID_W'(i);
            end
            if (w_is_refill[i]) begin
                w_rf_any = 1'b1;
                w_rf_low = MSHR_ID_W'(i);
            end
        end
    end

    // Keep a stalled offer pinned so a newly eligible lower entry cannot swap it out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_l2_hold    <= 1'b0;
            r_l2_hold_id <= '0;
            r_rf_hold    <= 1'b0;
            r_rf_hold_id <= '0;
        end else begin
            r_l2_hold    <= l2_req_vld_o & ~l2_req_rdy_i;
            r_l2_hold_id <= w_l2_sel;
            r_rf_hold    <= refill_vld_o & ~refill_rdy_i;
            r_rf_hold_id <= w_rf_sel;
        end
    end

    assign w_l2_sel           = r_l2_hold ? r_l2_hold_id : w_req_low;
    assign w_rf_sel           = r_rf_hold ? r_rf_hold_id : w_rf_low;

    assign l2_req_vld_o       = r_l2_hold | w_req_any;
    assign l2_req_mshr_id_o   = w_l2_sel;
    assign l2_req_line_addr_o = w_line_addr[w_l2_sel];

    assign refill_vld_o       = r_rf_hold | w_rf_any;
    assign refill_mshr_id_o   = w_rf_sel;
    assign refill_line_addr_o = w_line_addr[w_rf_sel];

    assign w_match_any        = |w_match;
    assign w_block_any        = |w_block;
    assign miss_rdy_o         = miss_vld_i & ~w_block_any & (w_match_any | alloc_has_free_i);
    assign miss_merged_o      = w_match_any;
    assign miss_mshr_id_o     = w_match_any ? w_match_id : alloc_id_i;
    assign mshr_bank_valid_o  = w_valid;

    // A line may be outstanding in only one entry
    a_single_match: assert property (@(posedge clk) disable iff (rst) $onehot0(w_match));

    // L2 must only answer entries that are waiting for data
    a_resp_legal: assert property (@(posedge clk) disable iff (rst)
        l2_resp_vld_i |-> w_is_wait[l2_resp_mshr_id_i]);

endmodule
`default_nettype wire

// File: tb/tb_rvh_l1d_mshr_table.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvh_l1d_mshr_table
//  Brief    : Self-checking bench for rvh_l1d_mshr_table with a per-line
//             miss-tracking reference model, directed scenarios and random
//             traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rvh_l1d_mshr_table;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_vld_i;
    logic [33:0] miss_line_addr_i;
    logic        miss_rdy_o;
    logic [1:0]  miss_mshr_id_o;
    logic        miss_merged_o;
    logic        alloc_has_free_i;
    logic [1:0]  alloc_id_i;
    logic [3:0]  mshr_bank_valid_o;
    logic        l2_req_vld_o;
    logic        l2_req_rdy_i;
    logic [33:0] l2_req_line_addr_o;
    logic [1:0]  l2_req_mshr_id_o;
    logic        l2_resp_vld_i;
    logic [1:0]  l2_resp_mshr_id_i;
    logic        refill_vld_o;
    logic        refill_rdy_i;
    logic [1:0]  refill_mshr_id_o;
    logic [33:0] refill_line_addr_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which entries hold a miss, whether the L2 request has
    // gone out, whether data has come back, and the line tracked
    bit          m_used [4];
    bit          m_sent [4];
    bit          m_data [4];
    logic [33:0] m_addr [4];
    int          m_l2_offer = -1;
    int          m_rf_offer = -1;

    // Last sampled DUT outputs, for directed checks
    logic        s_rdy, s_merged, s_l2vld, s_rfvld;
    logic [1:0]  s_id, s_l2id, s_rfid;
    logic [3:0]  s_valid;
    logic [33:0] s_l2addr, s_rfaddr;

    rvh_l1d_mshr_table u_dut (
        .clk                (clk),
        .rst                (rst),
        .miss_vld_i         (miss_vld_i),
        .miss_line_addr_i   (miss_line_addr_i),
        .miss_rdy_o         (miss_rdy_o),
        .miss_mshr_id_o     (miss_mshr_id_o),
        .miss_merged_o      (miss_merged_o),
        .alloc_has_free_i   (alloc_has_free_i),
        .alloc_id_i         (alloc_id_i),
        .mshr_bank_valid_o  (mshr_bank_valid_o),
        .l2_req_vld_o       (l2_req_vld_o),
        .l2_req_rdy_i       (l2_req_rdy_i),
        .l2_req_line_addr_o (l2_req_line_addr_o),
        .l2_req_mshr_id_o   (l2_req_mshr_id_o),
        .l2_resp_vld_i      (l2_resp_vld_i),
        .l2_resp_mshr_id_i  (l2_resp_mshr_id_i),
        .refill_vld_o       (refill_vld_o),
        .refill_rdy_i       (refill_rdy_i),
        .refill_mshr_id_o   (refill_mshr_id_o),
        .refill_line_addr_o (refill_line_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs (allocator from the model), check all outputs, advance the model
    task automatic step(input bit do_rst, input bit mv, input logic [33:0] ma, input bit l2rdy,
                        input bit rv, input logic [1:0] rid, input bit rfrdy);
        int         mid, l2s, rfs, fid, eid;
        bit         blk, free, e_rdy;
        logic [3:0] ev;
        @(negedge clk);
        free = 0;
        fid  = 0;
        for (int i = 3; i >= 0; i--) if (!m_used[i]) begin free = 1; fid = i; end
        rst               = do_rst;
        miss_vld_i        = mv;
        miss_line_addr_i  = ma;
        alloc_has_free_i  = free;
        alloc_id_i        = 2'(fid);
        l2_req_rdy_i      = l2rdy;
        l2_resp_vld_i     = rv;
        l2_resp_mshr_id_i = rid;
        refill_rdy_i      = rfrdy;
        #1;
        mid = -1;
        blk = 0;
        ev  = '0;
        for (int i = 0; i < 4; i++) begin
            ev[i] = m_used[i];
            if (m_used[i] && m_addr[i] == ma) begin
                if (m_data[i]) blk = 1;
                else           mid = i;
            end
        end
        l2s = m_l2_offer;
        if (l2s < 0) for (int i = 3; i >= 0; i--) if (m_used[i] && !m_sent[i]) l2s = i;
        rfs = m_rf_offer;
        if (rfs < 0) for (int i = 3; i >= 0; i--) if (m_used[i] && m_data[i]) rfs = i;
        e_rdy = mv && !blk && (mid >= 0 || free);
        eid   = (mid >= 0) ? mid : fid;

        s_rdy = miss_rdy_o; s_merged = miss_merged_o; s_id = miss_mshr_id_o;
        s_valid = mshr_bank_valid_o;
        s_l2vld = l2_req_vld_o; s_l2id = l2_req_mshr_id_o; s_l2addr = l2_req_line_addr_o;
        s_rfvld = refill_vld_o; s_rfid = refill_mshr_id_o; s_rfaddr = refill_line_addr_o;

        check("bank_valid", s_valid, ev);
        check("miss_rdy", s_rdy, e_rdy);
        check("miss_merged", s_merged, mid >= 0);
        check("miss_id", s_id, 64'(eid));
        check("l2_vld", s_l2vld, l2s >= 0);
        if (l2s >= 0) begin
            check("l2_id", s_l2id, 64'(l2s));
            check("l2_addr", s_l2addr, m_addr[l2s]);
        end
        check("refill_vld", s_rfvld, rfs >= 0);
        if (rfs >= 0) begin
            check("refill_id", s_rfid, 64'(rfs));
            check("refill_addr", s_rfaddr, m_addr[rfs]);
        end

        @(posedge clk);
        if (do_rst) begin
            for (int i = 0; i < 4; i++) begin
                m_used[i] = 0; m_sent[i] = 0; m_data[i] = 0; m_addr[i] = '0;
            end
            m_l2_offer = -1;
            m_rf_offer = -1;
        end else begin
            m_l2_offer = -1;
            if (l2s >= 0) begin
                if (l2rdy) m_sent[l2s] = 1;
                else       m_l2_offer = l2s;
            end
            if (rv) m_data[rid] = 1;
            m_rf_offer = -1;
            if (rfs >= 0) begin
                if (rfrdy) m_used[rfs] = 0;
                else       m_rf_offer = rfs;
            end
            if (e_rdy && mid < 0) begin
                m_used[fid] = 1; m_sent[fid] = 0; m_data[fid] = 0; m_addr[fid] = ma;
            end
        end
    endtask

    task automatic idle(input bit l2rdy, input bit rfrdy);
        step(0, 0, 34'h0, l2rdy, 0, 2'd0, rfrdy);
    endtask

    initial begin
        int         ncand;
        int         cand [4];
        bit         rv, dr;
        logic [1:0] rid;

        rst = 1'b1; miss_vld_i = 0; miss_line_addr_i = '0; alloc_has_free_i = 0; alloc_id_i = '0;
        l2_req_rdy_i = 0; l2_resp_vld_i = 0; l2_resp_mshr_id_i = '0; refill_rdy_i = 0;
        for (int i = 0; i < 4; i++) begin
            m_used[i] = 0; m_sent[i] = 0; m_data[i] = 0; m_addr[i] = '0;
        end

        step(1, 0, 34'h0, 0, 0, 2'd0, 0);
        step(1, 0, 34'h0, 0, 0, 2'd0, 0);

        // Reset state, then a first miss opens entry 0 and requests it
        step(0, 1, 34'h100, 0, 0, 2'd0, 0);
        check("t1_reset_valid", s_valid, 4'b0000);
        check("t1_rdy", s_rdy, 1);
        check("t1_merged", s_merged, 0);
        check("t1_id", s_id, 0);
        idle(1, 0);
        check("t1_valid", s_valid, 4'b0001);
        check("t1_l2_vld", s_l2vld, 1);
        check("t1_l2_addr", s_l2addr, 34'h100);
        check("t1_l2_id", s_l2id, 0);

        // Secondary miss while waiting for data merges
        step(0, 1, 34'h100, 0, 0, 2'd0, 0);
        check("t2_merged", s_merged, 1);
        check("t2_id", s_id, 0);
        idle(0, 0);
        check("t2_valid", s_valid, 4'b0001);

        // Response -> refill offered next cycle, held stable under backpressure
        step(0, 0, 34'h0, 0, 1, 2'd0, 0);
        for (int k = 0; k < 3; k++) begin
            idle(0, 0);
            check("t3_rf_vld", s_rfvld, 1);
            check("t3_rf_addr", s_rfaddr, 34'h100);
        end
        idle(0, 1);
        idle(0, 0);
        check("t3_valid_clear", s_valid, 4'b0000);

        // Fill the table; a new line is refused, a matching line merges
        step(0, 1, 34'h110, 1, 0, 2'd0, 0);
        step(0, 1, 34'h120, 1, 0, 2'd0, 0);
        step(0, 1, 34'h130, 1, 0, 2'd0, 0);
        step(0, 1, 34'h140, 1, 0, 2'd0, 0);
        idle(1, 0);
        step(0, 1, 34'h500, 0, 0, 2'd0, 0);
        check("t4_full_rdy", s_rdy, 0);
        step(0, 1, 34'h130, 0, 0, 2'd0, 0);
        check("t4_merge_rdy", s_rdy, 1);
        check("t4_merge", s_merged, 1);
        check("t4_merge_id", s_id, 2);

        // Miss to a line in refill stalls until the entry retires, then allocates fresh
        step(0, 0, 34'h0, 0, 1, 2'd1, 0);
        step(0, 1, 34'h120, 0, 0, 2'd0, 0);
        check("t5_stall0", s_rdy, 0);
        step(0, 1, 34'h120, 0, 0, 2'd0, 0);
        check("t5_stall1", s_rdy, 0);
        step(0, 1, 34'h120, 0, 0, 2'd0, 1);
        check("t5_stall2", s_rdy, 0);
        step(0, 1, 34'h120, 0, 0, 2'd0, 0);
        check("t5_rdy", s_rdy, 1);
        check("t5_new", s_merged, 0);
        check("t5_id", s_id, 1);

        // Reset with requests pending clears everything
        step(1, 0, 34'h0, 0, 0, 2'd0, 0);
        step(0, 1, 34'h100, 0, 0, 2'd0, 0);
        step(0, 1, 34'h200, 0, 0, 2'd0, 0);
        step(0, 1, 34'h300, 0, 0, 2'd0, 0);
        step(1, 0, 34'h0, 0, 0, 2'd0, 0);
        idle(0, 0);
        check("t6_valid", s_valid, 4'b0000);
        check("t6_l2_vld", s_l2vld, 0);
        check("t6_l2_addr", s_l2addr, 34'h0);
        check("t6_rf_vld", s_rfvld, 0);
        check("t6_rf_addr", s_rfaddr, 34'h0);
        check("t6_rdy", s_rdy, 0);
        check("t6_merged", s_merged, 0);

        // Random traffic; L2 answers only entries that are waiting for data
        for (int n = 0; n < 3000; n++) begin
            ncand = 0;
            for (int i = 0; i < 4; i++) if (m_used[i] && m_sent[i] && !m_data[i]) begin
                cand[ncand] = i;
                ncand++;
            end
            dr  = ($urandom_range(0, 399) == 0);
            rv  = !dr && (ncand > 0) && ($urandom_range(0, 2) == 0);
            rid = rv ? 2'(cand[$urandom_range(0, ncand - 1)]) : 2'd0;
            step(dr, ($urandom_range(0, 4) < 3), 34'(34'h100 * $urandom_range(1, 6)),
                 1'($urandom_range(0, 1)), rv, rid, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
